// File: rtl/hazard_issue_ctrl_pkg.sv
// Shared ISA definitions for the fetch/issue sequencer: opcodes, NOP word,
// FSM state codes and the instruction field decoder.
package hazard_issue_ctrl_pkg;

  localparam logic [2:0]  OP_RTYPE = 3'b000;
  localparam logic [2:0]  OP_IMM_A = 3'b001;
  localparam logic [2:0]  OP_IMM_B = 3'b010;
  localparam logic [2:0]  OP_BR    = 3'b100;
  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_BR_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic       writes;
    logic [2:0] rd;
    logic       ra_v;
    logic [2:0] ra;
    logic       rb_v;
    logic [2:0] rb;
    logic       is_branch;
  } dec_t;

  // The all-zero word would otherwise decode as an R-type touching r0.
  function automatic dec_t decode_inst(input logic [15:0] inst);
    dec_t d;
    d = '0;
    if (inst != NOP_WORD) begin
      case (inst[15:13])
        OP_RTYPE: begin
          d.writes = 1'b1;
          d.rd     = inst[8:6];
          d.ra_v   = 1'b1;
          d.ra     = inst[5:3];
          d.rb_v   = 1'b1;
          d.rb     = inst[2:0];
        end
        OP_IMM_A, OP_IMM_B: begin
          d.writes = 1'b1;
          d.rd     = inst[2:0];
          d.ra_v   = 1'b1;
          d.ra     = inst[5:3];
        end
        OP_BR:   d.is_branch = 1'b1;
        default: d = '0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/hazard_issue_ctrl_scoreboard.sv
// hazard_scoreboard: RAW_DIST-deep shift register of in-flight destination
// registers; flags a hit when either read register matches a valid slot.
module hazard_scoreboard #(
  parameter int RAW_DIST = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_v,
  input  logic [2:0] push_rd,
  input  logic       rd_a_v,
  input  logic [2:0] rd_a,
  input  logic       rd_b_v,
  input  logic [2:0] rd_b,
  output logic       hit
);

  logic       slot_v_q  [RAW_DIST];
  logic [2:0] slot_rd_q [RAW_DIST];
  logic       slot_v_d  [RAW_DIST];
  logic [2:0] slot_rd_d [RAW_DIST];

  always_comb begin
    slot_v_d[0]  = push_v;
    slot_rd_d[0] = push_rd;
    for (int i = 1; i < RAW_DIST; i++) begin
      slot_v_d[i]  = slot_v_q[i-1];
      slot_rd_d[i] = slot_rd_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAW_DIST; i++) begin
        slot_v_q[i]  <= 1'b0;
        slot_rd_q[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < RAW_DIST; i++) begin
        slot_v_q[i]  <= slot_v_d[i];
        slot_rd_q[i] <= slot_rd_d[i];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < RAW_DIST; i++) begin
      if (slot_v_q[i] && ((rd_a_v && (slot_rd_q[i] == rd_a)) ||
                          (rd_b_v && (slot_rd_q[i] == rd_b))))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_issue_ctrl.sv
// Fetch/issue sequencer: owns the PC, inserts RAW and branch-shadow bubbles.
// Define HAZ_PERF_CNT_EN to add saturating raw_bubbles/br_bubbles counters.
module hazard_issue_ctrl
  import hazard_issue_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int INST_W     = 16,
  parameter int RAW_DIST   = 3,
  parameter int BR_BUBBLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [INST_W-1:0] inst_in,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [INST_W-1:0] issue_inst,
  output logic              issue_valid,
  output logic              stall,
  output logic              br_wait
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]       raw_bubbles,
  output logic [15:0]       br_bubbles
`endif
);

  localparam int CNT_W = (BR_BUBBLES > 1) ? $clog2(BR_BUBBLES) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] issue_inst_q, issue_inst_d;
  logic              issue_valid_q, issue_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_v;
  logic              hit;
  dec_t              dec;

  assign dec = decode_inst(inst_in[15:0]);

  hazard_scoreboard #(
    .RAW_DIST (RAW_DIST)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .push_v  (push_v),
    .push_rd (dec.rd),
    .rd_a_v  (dec.ra_v),
    .rd_a    (dec.ra),
    .rd_b_v  (dec.rb_v),
    .rd_b    (dec.rb),
    .hit     (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      issue_inst_q  <= '0;
      issue_valid_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      issue_inst_q  <= issue_inst_d;
      issue_valid_q <= issue_valid_d;
      cnt_q         <= cnt_d;
    end
  end

  // A branch leaving RUN always enters BR_WAIT, even if run drops the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_RUN;
      S_RUN: begin
        if (!hit && dec.is_branch) state_d = S_BR_WAIT;
        else if (!run)             state_d = S_IDLE;
      end
      S_BR_WAIT: if (cnt_q == '0) state_d = run ? S_RUN : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    issue_inst_d  = INST_W'(NOP_WORD);
    issue_valid_d = 1'b0;
    cnt_d         = cnt_q;
    push_v        = 1'b0;
    stall         = 1'b0;
    case (state_q)
      S_RUN: begin
        if (hit) begin
          stall = 1'b1;
        end else begin
          issue_inst_d  = inst_in;
          issue_valid_d = 1'b1;
          pc_d          = pc_q + ADDR_W'(1);
          push_v        = dec.writes;
          if (dec.is_branch) cnt_d = CNT_W'(BR_BUBBLES - 1);
        end
      end
      S_BR_WAIT: begin
        if (cnt_q == '0) begin
          if (br_taken) pc_d = br_target;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign fetch_addr  = pc_q;
  assign issue_inst  = issue_inst_q;
  assign issue_valid = issue_valid_q;
  assign br_wait     = (state_q == S_BR_WAIT);

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] raw_bubbles_q, raw_bubbles_d;
  logic [15:0] br_bubbles_q, br_bubbles_d;

  always_comb begin
    raw_bubbles_d = raw_bubbles_q;
    br_bubbles_d  = br_bubbles_q;
    if (stall && (raw_bubbles_q != 16'hFFFF))   raw_bubbles_d = raw_bubbles_q + 16'd1;
    if (br_wait && (br_bubbles_q != 16'hFFFF))  br_bubbles_d  = br_bubbles_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_bubbles_q <= '0;
      br_bubbles_q  <= '0;
    end else begin
      raw_bubbles_q <= raw_bubbles_d;
      br_bubbles_q  <= br_bubbles_d;
    end
  end

  assign raw_bubbles = raw_bubbles_q;
  assign br_bubbles  = br_bubbles_q;
`endif

endmodule
